// File: rtl/ft601_ch_arbiter.sv
// ft601_ch_arbiter
// Schedules the shared FT601 multi-channel FIFO bus between the PL-side
// channels. It picks one channel and one direction by round-robin, offers
// the grant to the bus engine, counts words so a packet never exceeds
// MAX_PACKET_SIZE, and inserts a turnaround gap after each grant.
//
// Ports:
//   clk, reset_n        FT601 bus clock, asynchronous active-low reset
//   enable              permits new grants (never aborts an active one)
//   tx_req, tx_ok       per-channel TX eligibility terms (bit i-1 = channel i)
//   rx_ok, rx_space     per-channel RX eligibility terms (bit i-1 = channel i)
//   grant_valid         a grant is being offered
//   grant_dir           0 = TX (PL to host), 1 = RX (host to PL)
//   grant_ch            granted channel 1..NUM_CHANNELS, 0 when none
//   grant_ack           engine accepts the offered grant
//   beat                one 32-bit word moved on the granted channel
//   done                engine ended the transfer early
//   last                current beat is the final one allowed (combinational)
//   busy                arbiter is not idle
module ft601_ch_arbiter #(
  parameter int NUM_CHANNELS    = 4,
  parameter int MAX_PACKET_SIZE = 1024,
  parameter int TURNAROUND      = 2,
  localparam int CW             = $clog2(NUM_CHANNELS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] tx_req,
  input  logic [NUM_CHANNELS-1:0] tx_ok,
  input  logic [NUM_CHANNELS-1:0] rx_ok,
  input  logic [NUM_CHANNELS-1:0] rx_space,
  output logic                    grant_valid,
  output logic                    grant_dir,
  output logic [CW-1:0]           grant_ch,
  input  logic                    grant_ack,
  input  logic                    beat,
  input  logic                    done,
  output logic                    last,
  output logic                    busy
);

  localparam int MAX_WORDS = MAX_PACKET_SIZE / 4;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int GAP_W     = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]             state;
  logic                   g_dir;
  logic [CW-1:0]          g_ch;
  logic                   last_dir;
  logic [CW-1:0]          ptr_tx;
  logic [CW-1:0]          ptr_rx;
  logic [CNT_W-1:0]       word_cnt;
  logic [GAP_W-1:0]       gap_cnt;

  logic [NUM_CHANNELS-1:0] tx_elig;
  logic [NUM_CHANNELS-1:0] rx_elig;
  logic [CW-1:0]           tx_pick;
  logic [CW-1:0]           rx_pick;
  logic                    any_tx;
  logic                    any_rx;
  logic                    sel_dir;
  logic [CW-1:0]           sel_ch;
  logic                    last_i;
  logic                    active;

  // Search starts at the channel after ptr and wraps N -> 1; returns the
  // first eligible channel number, or 0 if none is eligible.
  function automatic logic [CW-1:0] rr_pick(input logic [NUM_CHANNELS-1:0] elig,
                                            input logic [CW-1:0]           ptr);
    logic          found;
    logic [CW-1:0] pick;
    int unsigned   idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
      idx = (32'(ptr) + k - 1) % NUM_CHANNELS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = CW'(idx + 1);
      end
    end
    return pick;
  endfunction

  always_comb begin
    tx_elig = tx_req & tx_ok;
    rx_elig = rx_ok & rx_space;
    any_tx  = |tx_elig;
    any_rx  = |rx_elig;
    tx_pick = rr_pick(tx_elig, ptr_tx);
    rx_pick = rr_pick(rx_elig, ptr_rx);
    // With both directions pending, alternate against the last served one.
    if (any_tx && any_rx) begin
      sel_dir = ~last_dir;
    end else begin
      sel_dir = any_rx;
    end
    sel_ch = sel_dir ? rx_pick : tx_pick;
  end

  always_comb begin
    active      = (state == S_OFFER) || (state == S_XFER);
    grant_valid = (state == S_OFFER);
    grant_dir   = active ? g_dir : 1'b0;
    grant_ch    = active ? g_ch : '0;
    last_i      = (state == S_XFER) && beat && (word_cnt == CNT_W'(MAX_WORDS - 1));
    last        = last_i;
    busy        = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      g_dir    <= 1'b0;
      g_ch     <= '0;
      last_dir <= 1'b1;
      ptr_tx   <= CW'(NUM_CHANNELS);
      ptr_rx   <= CW'(NUM_CHANNELS);
      word_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && (any_tx || any_rx)) begin
            g_dir <= sel_dir;
            g_ch  <= sel_ch;
            state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (grant_ack) begin
            word_cnt <= '0;
            last_dir <= g_dir;
            if (g_dir) begin
              ptr_rx <= g_ch;
            end else begin
              ptr_tx <= g_ch;
            end
            state <= S_XFER;
          end
        end
        S_XFER: begin
          // The final beat leaves XFER, so the count stops at MAX_WORDS-1.
          if (beat && !last_i) begin
            word_cnt <= word_cnt + 1'b1;
          end
          if (done || last_i) begin
            if (TURNAROUND == 0) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= GAP_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
              state   <= S_GAP;
            end
          end
        end
        default: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft601_ch_arbiter.sv
// Directed testbench for ft601_ch_arbiter with default parameters
// (4 channels, 256-word packets, 2-cycle turnaround).
module tb_ft601_ch_arbiter;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] tx_req;
  logic [3:0] tx_ok;
  logic [3:0] rx_ok;
  logic [3:0] rx_space;
  logic       grant_valid;
  logic       grant_dir;
  logic [2:0] grant_ch;
  logic       grant_ack;
  logic       beat;
  logic       done;
  logic       last;
  logic       busy;

  int total = 0;
  int bad   = 0;

  ft601_ch_arbiter #(
    .NUM_CHANNELS   (4),
    .MAX_PACKET_SIZE(1024),
    .TURNAROUND     (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .tx_req     (tx_req),
    .tx_ok      (tx_ok),
    .rx_ok      (rx_ok),
    .rx_space   (rx_space),
    .grant_valid(grant_valid),
    .grant_dir  (grant_dir),
    .grant_ch   (grant_ch),
    .grant_ack  (grant_ack),
    .beat       (beat),
    .done       (done),
    .last       (last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (grant_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("wait_grant", {31'd0, grant_valid}, 32'd1);
  endtask

  // Accept a grant, end it with done one cycle after the ack, and check
  // the exact turnaround gap length.
  task automatic do_grant(input string tag, input logic exp_dir, input logic [2:0] exp_ch);
    wait_grant();
    check({tag, "_dir"}, {31'd0, grant_dir}, {31'd0, exp_dir});
    check({tag, "_ch"}, {29'd0, grant_ch}, {29'd0, exp_ch});
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    check({tag, "_xfer_ch"}, {29'd0, grant_ch}, {29'd0, exp_ch});
    done = 1'b1;
    step();
    done = 1'b0;
    check({tag, "_gap1"}, {30'd0, busy, grant_valid}, 32'd2);
    step();
    check({tag, "_gap2"}, {30'd0, busy, grant_valid}, 32'd2);
    step();
    check({tag, "_idle"}, {30'd0, busy, grant_valid}, 32'd0);
  endtask

  // Drive n consecutive beats; only the final one may raise last.
  task automatic burst(input string tag, input int n, input logic exp_final);
    int lasts;
    lasts = 0;
    for (int i = 1; i <= n; i++) begin
      beat = 1'b1;
      #1;
      if (last === 1'b1) lasts++;
      if (i == n) check({tag, "_final_last"}, {31'd0, last}, {31'd0, exp_final});
      step();
    end
    beat = 1'b0;
    check({tag, "_last_count"}, 32'(lasts), {31'd0, exp_final});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    tx_req    = 4'b0101;
    tx_ok     = 4'hF;
    rx_ok     = 4'h0;
    rx_space  = 4'h0;
    grant_ack = 1'b0;
    beat      = 1'b0;
    done      = 1'b0;
    #2;
    check("reset_outputs", {25'd0, grant_valid, grant_dir, grant_ch, last, busy}, 32'd0);
    step();
    reset_n = 1'b1;

    // TX-only round robin over ch1 and ch3
    do_grant("t1_g1", 1'b0, 3'd1);
    do_grant("t1_g2", 1'b0, 3'd3);
    do_grant("t1_g3", 1'b0, 3'd1);
    do_grant("t1_g4", 1'b0, 3'd3);

    // Direction alternation, TX first after reset
    tx_req   = 4'b0010;
    tx_ok    = 4'b0010;
    rx_ok    = 4'b1000;
    rx_space = 4'b1000;
    do_reset();
    do_grant("t2_g1", 1'b0, 3'd2);
    do_grant("t2_g2", 1'b1, 3'd4);
    do_grant("t2_g3", 1'b0, 3'd2);
    do_grant("t2_g4", 1'b1, 3'd4);

    // Full-length packet ends on beat 256
    tx_req   = 4'b0001;
    tx_ok    = 4'b0001;
    rx_ok    = 4'h0;
    rx_space = 4'h0;
    do_reset();
    wait_grant();
    check("t3_ch", {29'd0, grant_ch}, 32'd1);
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    burst("t3_b255", 255, 1'b0);
    burst("t3_b256", 1, 1'b1);
    check("t3_gap", {26'd0, busy, grant_valid, grant_dir, grant_ch}, 32'h20);

    // OFFER holds steady while inputs churn and beats are ignored
    wait_grant();
    check("t4_ch", {29'd0, grant_ch}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tx_req   = 4'($urandom);
      tx_ok    = 4'($urandom);
      rx_ok    = 4'($urandom);
      rx_space = 4'($urandom);
      beat     = 1'(i);
      step();
      check("t4_hold", {27'd0, grant_valid, grant_dir, grant_ch}, 32'h11);
    end
    beat     = 1'b0;
    tx_req   = 4'b0001;
    tx_ok    = 4'b0001;
    rx_ok    = 4'h0;
    rx_space = 4'h0;
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    burst("t4_b255", 255, 1'b0);
    burst("t4_b256", 1, 1'b1);

    // enable drop mid-transfer lets the grant finish, then blocks new ones
    wait_grant();
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    enable = 1'b0;
    tx_req = 4'h0;
    tx_ok  = 4'h0;
    step();
    check("t5_still_xfer", {28'd0, busy, grant_ch}, 32'h9);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    step();
    step();
    check("t5_idle", {30'd0, busy, grant_valid}, 32'd0);
    tx_req = 4'b0001;
    tx_ok  = 4'b0001;
    step();
    step();
    step();
    check("t5_blocked", {30'd0, busy, grant_valid}, 32'd0);
    enable = 1'b1;
    step();
    check("t5_reenabled", {28'd0, grant_valid, grant_ch}, 32'h9);

    // Asynchronous reset mid-XFER restores pointers and direction history
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    check("t6_in_xfer", {28'd0, busy, grant_ch}, 32'h9);
    tx_req   = 4'hF;
    tx_ok    = 4'hF;
    rx_ok    = 4'hF;
    rx_space = 4'hF;
    beat     = 1'b1;
    reset_n  = 1'b0;
    #1;
    check("t6_async_reset", {25'd0, grant_valid, grant_dir, grant_ch, last, busy}, 32'd0);
    beat = 1'b0;
    #2;
    reset_n = 1'b1;
    wait_grant();
    check("t6_first_dir", {31'd0, grant_dir}, 32'd0);
    check("t6_first_ch", {29'd0, grant_ch}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
